decade_count_ctrl: RTL and testbench

Sequencing controller for the 3-digit BCD `multi_decade_counter` (ones/tens/hundreds, enable, saturation, active-low `reset_n`).
- Generates prescaled count-enable pulses and clears the counter.
- Runs/pauses counting on command and watches the counter's digits against a programmed BCD target.
- Stops counting and flags completion on match, or flags an error on saturation.
- Sits between the control/register interface and the counter instance; the counter itself stays unmodified.

---
 rtl/decade_ctrl_pkg.sv | 28 ++
 rtl/prescale_tick.sv | 37 +++
 rtl/decade_count_ctrl.sv | 145 ++++++++++++++
 tb/tb_decade_count_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decade_ctrl_pkg.sv
// Shared types and constants for the decade counter sequencing controller.
package decade_ctrl_pkg;

  typedef enum logic [2:0] {
    StClear  = 3'd0,
    StIdle   = 3'd1,
    StRun    = 3'd2,
    StPaused = 3'd3,
    StDone   = 3'd4
  } ctrl_state_e;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam int unsigned CLEAR_CYCLES = 2;

  typedef logic [1:0] clr_cnt_t;

  typedef struct packed {
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd3_t;

  function automatic logic bcd3_valid(bcd3_t v);
    return (v.hundreds <= BCD_MAX_DIGIT) && (v.tens <= BCD_MAX_DIGIT) &&
           (v.ones <= BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/prescale_tick.sv
// Modulo-PRESCALE cycle counter with hold (en low) and synchronous clear.
// tick is high in the last cycle of each period while advancing.
module prescale_tick #(
  parameter int unsigned PRESCALE   = 100,
  parameter int unsigned PRESCALE_W = $clog2(PRESCALE)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  logic [PRESCALE_W-1:0] count_q, count_d;
  logic                  last;

  assign last = (count_q == PRESCALE_W'(PRESCALE - 1));
  assign tick = en && last;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = last ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/decade_count_ctrl.sv
// Sequencing controller for the 3-digit BCD counter: clears it, issues prescaled
// enable pulses, and stops on a target match or flags saturation.
module decade_count_ctrl
  import decade_ctrl_pkg::*;
#(
  parameter int unsigned PRESCALE   = 100,
  parameter int unsigned PRESCALE_W = $clog2(PRESCALE)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic [3:0] target_ones,
  input  logic [3:0] target_tens,
  input  logic [3:0] target_hundreds,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [3:0] hundreds,
  input  logic       saturation,
  output logic       cnt_enable,
  output logic       cnt_reset_n,
  output logic       busy,
  output logic       done,
  output logic       overflow_err,
  output logic       cfg_err
);

  ctrl_state_e state_q, state_d;
  clr_cnt_t    clr_cnt_q, clr_cnt_d;
  bcd3_t       target_q, target_d;
  bcd3_t       target_in, digits;
  logic        overflow_q, overflow_d;
  logic        cfg_err_d;
  logic        cnt_enable_q, cnt_reset_n_q, busy_q, done_q, cfg_err_q;
  logic        pre_en, pre_clear, pre_tick;

  assign target_in = {target_hundreds, target_tens, target_ones};
  assign digits    = {hundreds, tens, ones};

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    target_d   = target_q;
    overflow_d = overflow_q;
    cfg_err_d  = 1'b0;
    pre_en     = 1'b0;

    if (clear) begin
      state_d    = StClear;
      clr_cnt_d  = clr_cnt_t'(CLEAR_CYCLES);
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        StClear: begin
          if (clr_cnt_q <= clr_cnt_t'(1)) begin
            state_d = StIdle;
          end else begin
            clr_cnt_d = clr_cnt_q - 1'b1;
          end
        end
        StIdle: begin
          if (start) begin
            if (!bcd3_valid(target_in)) begin
              cfg_err_d = 1'b1;
            end else begin
              target_d = target_in;
              state_d  = (digits == target_in) ? StDone : StRun;
            end
          end
        end
        StRun: begin
          // Stop freezes the prescaler phase; the pending tick is not issued.
          if (stop) begin
            state_d = StPaused;
          end else if (digits == target_q) begin
            state_d = StDone;
          end else if (saturation) begin
            state_d    = StDone;
            overflow_d = 1'b1;
          end else begin
            pre_en = 1'b1;
          end
        end
        StPaused: begin
          if (start && !stop) begin
            state_d = StRun;
          end
        end
        StDone: begin
          state_d = StDone;
        end
        default: begin
          state_d   = StClear;
          clr_cnt_d = clr_cnt_t'(CLEAR_CYCLES);
        end
      endcase
    end

    pre_clear = !(state_d inside {StRun, StPaused});
  end

  prescale_tick #(
    .PRESCALE  (PRESCALE),
    .PRESCALE_W(PRESCALE_W)
  ) u_prescale_tick (
    .clk  (clk),
    .reset(reset),
    .clear(pre_clear),
    .en   (pre_en),
    .tick (pre_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StClear;
      clr_cnt_q     <= clr_cnt_t'(CLEAR_CYCLES);
      target_q      <= '0;
      overflow_q    <= 1'b0;
      cnt_enable_q  <= 1'b0;
      cnt_reset_n_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      target_q      <= target_d;
      overflow_q    <= overflow_d;
      cnt_enable_q  <= pre_tick;
      cnt_reset_n_q <= (state_d != StClear);
      busy_q        <= (state_d inside {StRun, StPaused});
      done_q        <= (state_d == StDone);
      cfg_err_q     <= cfg_err_d;
    end
  end

  assign cnt_enable   = cnt_enable_q;
  assign cnt_reset_n  = cnt_reset_n_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign overflow_err = overflow_q;
  assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_decade_count_ctrl.sv
// Bench for decade_count_ctrl: counter model as load, behavioural reference with
// per-cycle output comparison, plus directed literal checks.
module tb_decade_count_ctrl;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       reset, start, stop, clear;
  logic [3:0] target_ones, target_tens, target_hundreds;
  logic [3:0] ones, tens, hundreds;
  logic       saturation;
  logic       cnt_enable, cnt_reset_n, busy, done, overflow_err, cfg_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  decade_count_ctrl #(
    .PRESCALE(P)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .stop           (stop),
    .clear          (clear),
    .target_ones    (target_ones),
    .target_tens    (target_tens),
    .target_hundreds(target_hundreds),
    .ones           (ones),
    .tens           (tens),
    .hundreds       (hundreds),
    .saturation     (saturation),
    .cnt_enable     (cnt_enable),
    .cnt_reset_n    (cnt_reset_n),
    .busy           (busy),
    .done           (done),
    .overflow_err   (overflow_err),
    .cfg_err        (cfg_err)
  );

  // Load: decimal counter with adjustable saturation point.
  int cnt_val = 0;
  int sat_lim = 999;
  always @(posedge clk) begin
    if (cnt_reset_n === 1'b0) cnt_val <= 0;
    else if (cnt_enable === 1'b1 && cnt_val < sat_lim) cnt_val <= cnt_val + 1;
  end
  assign ones       = 4'(cnt_val % 10);
  assign tens       = 4'((cnt_val / 10) % 10);
  assign hundreds   = 4'(cnt_val / 100);
  assign saturation = (cnt_val >= sat_lim);

  // Reference: mode as plain int, enable phase from total run cycles modulo P.
  localparam int MClr = 0, MIdle = 1, MRun = 2, MPause = 3, MDone = 4;
  int   mode = MClr, clr_left = 0, tgt = 0, runs = 0;
  bit   model_valid = 0;
  logic e_en, e_rstn, e_busy, e_done, e_ovf, e_cfg;

  always @(posedge clk) begin
    e_en  = 1'b0;
    e_cfg = 1'b0;
    if (reset) begin
      mode = MClr; clr_left = 2; e_ovf = 1'b0; model_valid = 1;
    end else if (clear) begin
      mode = MClr; clr_left = 2; e_ovf = 1'b0;
    end else begin
      case (mode)
        MClr: begin
          clr_left = clr_left - 1;
          if (clr_left == 0) mode = MIdle;
        end
        MIdle: if (start) begin
          if (target_hundreds > 9 || target_tens > 9 || target_ones > 9) e_cfg = 1'b1;
          else begin
            tgt  = 100 * int'(target_hundreds) + 10 * int'(target_tens) + int'(target_ones);
            runs = 0;
            mode = (cnt_val == tgt) ? MDone : MRun;
          end
        end
        MRun: begin
          if (stop) mode = MPause;
          else if (cnt_val == tgt) mode = MDone;
          else if (saturation) begin mode = MDone; e_ovf = 1'b1; end
          else begin
            runs = runs + 1;
            e_en = (runs % P == 0);
          end
        end
        MPause: if (start && !stop) mode = MRun;
        default: ;
      endcase
    end
    e_rstn = (mode != MClr);
    e_busy = (mode == MRun || mode == MPause);
    e_done = (mode == MDone);
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmd(input logic c, input logic s, input logic t);
    clear = c; stop = s; start = t;
    @(negedge clk);
    clear = 1'b0; stop = 1'b0; start = 1'b0;
  endtask

  task automatic set_target(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    target_hundreds = h; target_tens = t; target_ones = o;
  endtask

  task automatic cycles(input int n, output int pulses, output int cfgs);
    pulses = 0; cfgs = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (cnt_enable) pulses++;
      if (cfg_err) cfgs++;
    end
  endtask

  task automatic wait_done(input int bound, inout int pulses);
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk);
      if (cnt_enable) pulses++;
    end
    check("done_within_bound", int'(done), 1);
  endtask

  task automatic check_clear_seq(input string tag);
    check({tag, "_rstn_c1"}, int'(cnt_reset_n), 0);
    check({tag, "_flags_c1"}, int'({done, overflow_err, busy, cnt_enable}), 0);
    @(negedge clk);
    check({tag, "_rstn_c2"}, int'(cnt_reset_n), 0);
    @(negedge clk);
    check({tag, "_rstn_idle"}, int'(cnt_reset_n), 1);
  endtask

  initial begin
    int np, nc;
    reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
    set_target(4'd0, 4'd0, 4'd0);
    fork
      forever begin
        @(negedge clk);
        if (model_valid) begin
          vectors++;
          if ({cnt_enable, cnt_reset_n, busy, done, overflow_err, cfg_err} !==
              {e_en, e_rstn, e_busy, e_done, e_ovf, e_cfg}) begin
            miscompares++;
            $display("FAIL cycle_cmp at %0t: en,rstn,busy,done,ovf,cfg got %b expected %b",
                     $time, {cnt_enable, cnt_reset_n, busy, done, overflow_err, cfg_err},
                     {e_en, e_rstn, e_busy, e_done, e_ovf, e_cfg});
          end
        end
      end
    join_none

    // 1: reset release
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_clear_seq("reset");
    check("reset_idle_flags", int'({busy, done, overflow_err, cfg_err, cnt_enable}), 0);

    // 2: target 025 straight run
    set_target(4'd0, 4'd2, 4'd5);
    cmd(1'b0, 1'b0, 1'b1);
    check("run_busy", int'(busy), 1);
    np = 0;
    wait_done(200, np);
    check("run_pulses", np, 25);
    check("run_count", cnt_val, 25);
    check("run_busy_low", int'(busy), 0);
    cycles(20, np, nc);
    check("run_no_26th", np, 0);
    cmd(1'b1, 1'b0, 1'b0);
    check_clear_seq("clear1");

    // 3: pause after 10 pulses, resume with held phase
    cmd(1'b0, 1'b0, 1'b1);
    np = 0;
    for (int i = 0; i < 100 && np < 10; i++) begin
      @(negedge clk);
      if (cnt_enable) np++;
    end
    check("pause_pre_pulses", np, 10);
    cmd(1'b0, 1'b1, 1'b0);
    cycles(50, np, nc);
    check("pause_no_pulses", np, 0);
    check("pause_busy_done", int'({busy, done}), 2);
    cmd(1'b0, 1'b1, 1'b1);
    check("pause_start_stop_held", int'(busy), 1);
    cycles(10, np, nc);
    check("pause_still_held", np, 0);
    cmd(1'b0, 1'b0, 1'b1);
    np = 0;
    wait_done(200, np);
    check("resume_pulses", np, 15);
    check("resume_count", cnt_val, 25);
    cmd(1'b1, 1'b0, 1'b0);
    check_clear_seq("clear2");

    // 4a: target 999 meets saturation -> clean done
    set_target(4'd9, 4'd9, 4'd9);
    cmd(1'b0, 1'b0, 1'b1);
    np = 0;
    wait_done(4200, np);
    check("t999_count", cnt_val, 999);
    check("t999_no_ovf", int'(overflow_err), 0);
    cmd(1'b1, 1'b0, 1'b0);
    check_clear_seq("clear3");

    // 4b: illegal target digit
    set_target(4'hA, 4'd0, 4'd0);
    cmd(1'b0, 1'b0, 1'b1);
    check("cfg_pulse_now", int'(cfg_err), 1);
    cycles(10, np, nc);
    check("cfg_single", nc, 0);
    check("cfg_no_enable", np, 0);
    check("cfg_idle", int'({busy, done}), 0);

    // 5: forced saturation at 500, target 600
    sat_lim = 500;
    set_target(4'd6, 4'd0, 4'd0);
    cmd(1'b0, 1'b0, 1'b1);
    np = 0;
    wait_done(2200, np);
    check("sat_ovf", int'(overflow_err), 1);
    check("sat_count", cnt_val, 500);
    cmd(1'b1, 1'b0, 1'b0);
    check_clear_seq("clear4");
    check("sat_flags_cleared", int'({done, overflow_err}), 0);
    sat_lim = 999;

    // 6a: clear+stop+start together mid-run
    set_target(4'd0, 4'd2, 4'd5);
    cmd(1'b0, 1'b0, 1'b1);
    cycles(10, np, nc);
    cmd(1'b1, 1'b1, 1'b1);
    check_clear_seq("clear5");
    cycles(20, np, nc);
    check("clear_no_enable", np, 0);

    // 6b: reset mid-run
    cmd(1'b0, 1'b0, 1'b1);
    cycles(13, np, nc);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_clear_seq("reset2");
    cycles(20, np, nc);
    check("reset_no_enable", np, 0);
    check("reset_idle", int'({busy, done}), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
